// File: rtl/instruction_memory_pipelined.sv
// Pipelined instruction memory for the MIPS fetch stage.
// Requests are accepted on a valid/ready port. Responses come back in order
// after a fixed LATENCY and wait in a small FIFO when the consumer stalls.
// The program image is loaded through the write port, which keeps working
// while reset is held.
module instruction_memory_pipelined #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter     INIT_FILE  = "instructions.txt"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  Fault,
  input  logic                  WrEnable,
  input  logic [ADDR_WIDTH-1:0] WrAddress,
  input  logic [DATA_WIDTH-1:0] WrData
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FD = LATENCY + 1;          // response FIFO depth
  localparam int PW = $clog2(FD);           // FD >= 2, so PW >= 1
  localparam int CW = $clog2(LATENCY + 2);  // holds 0..LATENCY+1

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] req_idx, wr_idx;
  logic                  req_fault, wr_ok;
  logic                  accept, pop, push;

  // Read pipeline: one slot per cycle of latency.
  logic                  pv [LATENCY];
  logic                  pf [LATENCY];
  logic [DATA_WIDTH-1:0] pd [LATENCY];

  // Response FIFO.
  logic [DATA_WIDTH-1:0] fifo_data  [FD];
  logic                  fifo_fault [FD];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         fill;
  logic [CW-1:0]         outstanding;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address decode, handshakes and the output view of the FIFO head.
  always_comb begin
    req_idx     = ReqAddress >> 2;
    wr_idx      = WrAddress >> 2;
    req_fault   = (ReqAddress[1:0] != 2'b00) || (req_idx >= ADDR_WIDTH'(DEPTH));
    wr_ok       = (WrAddress[1:0] == 2'b00) && (wr_idx < ADDR_WIDTH'(DEPTH));
    ReqReady    = !reset && (outstanding < CW'(FD));
    RespValid   = (fill != '0);
    accept      = ReqValid && ReqReady;
    pop         = RespValid && RespReady;
    push        = pv[LATENCY-1];
    Instruction = RespValid ? fifo_data[rd_ptr] : '0;
    Fault       = RespValid && fifo_fault[rd_ptr];
  end

  // Write port: it ignores reset, and bad addresses are dropped.
  always_ff @(posedge clk) begin
    if (WrEnable && wr_ok)
      mem[wr_idx[IW-1:0]] <= WrData;
  end

  // Read at the accept edge. A same-edge write therefore returns old data.
  // Faulting requests carry zero data and never index the array.
  always_ff @(posedge clk) begin
    pd[0] <= req_fault ? '0 : mem[req_idx[IW-1:0]];
    pf[0] <= req_fault;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pd[i] <= pd[i-1];
      pf[i] <= pf[i-1];
    end
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++)
        pv[i] <= 1'b0;
    end else begin
      pv[0] <= accept;
      for (int unsigned i = 1; i < LATENCY; i++)
        pv[i] <= pv[i-1];
    end
  end

  // Response FIFO. It is written LATENCY edges after accept and popped on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr]  <= pd[LATENCY-1];
        fifo_fault[wr_ptr] <= pf[LATENCY-1];
        wr_ptr             <= bump(wr_ptr);
      end
      if (pop)
        rd_ptr <= bump(rd_ptr);
      fill <= fill + CW'(push) - CW'(pop);
    end
  end

  // Count of requests in the pipeline plus the FIFO.
  // This count is the only thing gating ReqReady.
  always_ff @(posedge clk) begin
    if (reset)
      outstanding <= '0;
    else
      outstanding <= outstanding + CW'(accept) - CW'(pop);
  end

  a_outstanding_bound : assert property (@(posedge clk) disable iff (reset)
                                         outstanding <= CW'(FD));

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Bench for instruction_memory_pipelined. Three instances (LATENCY 1, 2, 4)
// share one stimulus stream. Each instance is checked every cycle against a
// queue-based reference model of in-flight and buffered responses.
module tb_instruction_memory_pipelined;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int ND    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          resp_ready = 1'b0;
  logic          wr_enable = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [AW-1:0] wr_address = '0;
  logic [DW-1:0] wr_data = '0;

  logic          req_ready  [ND];
  logic          resp_valid [ND];
  logic          fault      [ND];
  logic [DW-1:0] instr      [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    instruction_memory_pipelined #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH(DEPTH),
      .LATENCY((g == 0) ? 1 : (g == 1) ? 2 : 4),
      .INIT_FILE("")
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .ReqValid(req_valid),
      .ReqReady(req_ready[g]),
      .ReqAddress(req_address),
      .RespValid(resp_valid[g]),
      .RespReady(resp_ready),
      .Instruction(instr[g]),
      .Fault(fault[g]),
      .WrEnable(wr_enable),
      .WrAddress(wr_address),
      .WrData(wr_data)
    );
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic        flt;
    int unsigned due;
  } ent_t;

  ent_t          infl [ND][$];
  ent_t          rsp  [ND][$];
  logic [DW-1:0] ref_mem [DEPTH];
  int unsigned   cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            dut_accepts [ND];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] wval(input int i);
    return 32'hC0DE_0000 | (i * 32'h0000_0111);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Applies one clock edge's worth of the interface rules to the model.
  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      bit   rdy;
      ent_t e;
      rdy = (int'(infl[d].size() + rsp[d].size()) < lat_of(d) + 1);
      if (reset) begin
        infl[d].delete();
        rsp[d].delete();
      end else begin
        if (rsp[d].size() > 0 && resp_ready) void'(rsp[d].pop_front());
        while (infl[d].size() > 0 && infl[d][0].due == cyc)
          rsp[d].push_back(infl[d].pop_front());
        if (req_valid && rdy) begin
          e.flt  = (req_address % 4 != 0) || (req_address / 4 >= DEPTH);
          e.data = e.flt ? 32'h0 : ref_mem[req_address / 4];
          e.due  = cyc + lat_of(d);
          infl[d].push_back(e);
        end
      end
    end
    if (wr_enable && wr_address % 4 == 0 && wr_address / 4 < DEPTH)
      ref_mem[wr_address / 4] = wr_data;
    cyc++;
  endtask

  task automatic check_outputs();
    for (int d = 0; d < ND; d++) begin
      bit exp_v, exp_r;
      exp_v = rsp[d].size() > 0;
      exp_r = !reset && (int'(infl[d].size() + rsp[d].size()) < lat_of(d) + 1);
      check($sformatf("resp_valid[L%0d]", lat_of(d)), 32'(resp_valid[d]), 32'(exp_v));
      check($sformatf("req_ready[L%0d]", lat_of(d)), 32'(req_ready[d]), 32'(exp_r));
      if (exp_v) begin
        check($sformatf("instruction[L%0d]", lat_of(d)), instr[d], rsp[d][0].data);
        check($sformatf("fault[L%0d]", lat_of(d)), 32'(fault[d]), 32'(rsp[d][0].flt));
      end
    end
  endtask

  // One clock: count DUT accepts, advance the model, then compare 1 time unit after the edge.
  task automatic step();
    for (int d = 0; d < ND; d++)
      if (req_valid && req_ready[d]) dut_accepts[d]++;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] v);
    wr_enable = 1'b1; wr_address = a; wr_data = v;
    step();
    wr_enable = 1'b0;
  endtask

  // Single request with RespReady high. The first response per instance is
  // recorded, along with how many edges after the accept it appeared.
  logic [31:0] got_i [ND];
  logic        got_f [ND];
  int          got_t [ND];

  task automatic fetch(input logic [31:0] a);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_address = a;
    step();
    req_valid = 1'b0; wr_enable = 1'b0;
    for (int d = 0; d < ND; d++) begin got_t[d] = 0; got_i[d] = 'x; got_f[d] = 1'bx; end
    for (int t = 1; t <= 8; t++) begin
      step();
      for (int d = 0; d < ND; d++)
        if (resp_valid[d] && got_t[d] == 0) begin
          got_t[d] = t; got_i[d] = instr[d]; got_f[d] = fault[d];
        end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_i;
    logic        exp_f;
  } vec_t;

  vec_t tv [9];
  int   seen;

  initial begin
    tv[0] = '{32'd0,           wval(0),  1'b0};
    tv[1] = '{32'd4,           wval(1),  1'b0};
    tv[2] = '{32'd8,           wval(2),  1'b0};
    tv[3] = '{32'd6,           32'h0,    1'b1};
    tv[4] = '{32'd4096,        32'h0,    1'b1};
    tv[5] = '{32'd4,           wval(1),  1'b0};
    tv[6] = '{32'd4092,        32'h7FF0_1023, 1'b0};
    tv[7] = '{32'hFFFF_FFFC,   32'h0,    1'b1};
    tv[8] = '{32'd2,           32'h0,    1'b1};
    for (int d = 0; d < ND; d++) dut_accepts[d] = 0;

    // Program load while reset is held.
    reset = 1'b1;
    for (int i = 0; i < 16; i++) write_word(32'(i * 4), wval(i));
    write_word(32'd4092, 32'h7FF0_1023);
    step();
    for (int d = 0; d < ND; d++) begin
      check("reset resp_valid", 32'(resp_valid[d]), 32'h0);
      check("reset req_ready", 32'(req_ready[d]), 32'h0);
      check("reset instruction", instr[d], 32'h0);
      check("reset fault", 32'(fault[d]), 32'h0);
    end
    reset = 1'b0;
    step();

    // Single requests from the vector table: data, fault and exact latency.
    foreach (tv[k]) begin
      fetch(tv[k].addr);
      for (int d = 0; d < ND; d++) begin
        check($sformatf("vec%0d latency[L%0d]", k, lat_of(d)), got_t[d], lat_of(d));
        check($sformatf("vec%0d instruction[L%0d]", k, lat_of(d)), got_i[d], tv[k].exp_i);
        check($sformatf("vec%0d fault[L%0d]", k, lat_of(d)), 32'(got_f[d]), 32'(tv[k].exp_f));
      end
    end

    // Back-to-back 0,4,8 with RespReady high. The model checks timing and order.
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin req_valid = 1'b1; req_address = 32'(i * 4); step(); end
    req_valid = 1'b0;
    repeat (6) step();

    // Back-pressure: exactly LATENCY+1 accepts, then drain in order.
    resp_ready = 1'b0;
    for (int d = 0; d < ND; d++) dut_accepts[d] = 0;
    for (int i = 0; i < 10; i++) begin req_valid = 1'b1; req_address = 32'((i % 16) * 4); step(); end
    for (int d = 0; d < ND; d++) begin
      check($sformatf("stall accepts[L%0d]", lat_of(d)), dut_accepts[d], lat_of(d) + 1);
      check($sformatf("stall req_ready[L%0d]", lat_of(d)), 32'(req_ready[d]), 32'h0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (8) step();
    for (int d = 0; d < ND; d++)
      check($sformatf("drained req_ready[L%0d]", lat_of(d)), 32'(req_ready[d]), 32'h1);

    // Write then read. A same-edge write returns old data. A misaligned write is dropped.
    write_word(32'd8, 32'hDEAD_BEEF);
    fetch(32'd8);
    for (int d = 0; d < ND; d++) check("write-read 8", got_i[d], 32'hDEAD_BEEF);
    wr_enable = 1'b1; wr_address = 32'd12; wr_data = 32'h1234_5678;
    fetch(32'd12);
    for (int d = 0; d < ND; d++) check("same-edge old data", got_i[d], wval(3));
    write_word(32'd10, 32'hBAD0_BAD0);
    fetch(32'd8);
    for (int d = 0; d < ND; d++) check("misaligned write dropped", got_i[d], 32'hDEAD_BEEF);
    fetch(32'd12);
    for (int d = 0; d < ND; d++) check("same-edge write landed", got_i[d], 32'h1234_5678);

    // Reset with requests in flight: nothing stale may appear afterwards.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_address = 32'd0; step();
    req_address = 32'd4; step();
    req_valid = 1'b0; reset = 1'b1; step();
    for (int d = 0; d < ND; d++)
      check("post-reset resp_valid", 32'(resp_valid[d]), 32'h0);
    reset = 1'b0; resp_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      step();
      for (int d = 0; d < ND; d++) if (resp_valid[d]) seen++;
    end
    check("stale responses after reset", seen, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int sel;
      reset      = ($urandom_range(0, 79) == 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 15);
      if (sel < 11)       req_address = 32'($urandom_range(0, 15) * 4);
      else if (sel < 13)  req_address = 32'($urandom_range(0, 63)) | 32'h1;
      else if (sel < 14)  req_address = 32'd4092;
      else                req_address = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      wr_enable = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 7);
      wr_address = (sel < 6) ? 32'($urandom_range(0, 15) * 4)
                 : (sel < 7) ? 32'($urandom_range(0, 63) * 4 + 2)
                             : 32'h2000;
      wr_data = $urandom;
      step();
    end
    reset = 1'b0; req_valid = 1'b0; wr_enable = 1'b0; resp_ready = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
